// File: rtl/rca_pkg.sv
// ----------------------------------------------------------------------------
// rca_pkg
//   Shared definitions for the segmented pipelined ripple-carry adder.
//   - nseg()           : number of ripple segments (pipeline stages) for a
//                        WIDTH / SEG_W split.
//   - seg_t            : one default-width ripple segment.
//   - RCA_WIDTH_CHECK  : macro placed in a module body. It stops elaboration
//                        when WIDTH is not a positive multiple of SEG_W.
//   No ports (package).
// ----------------------------------------------------------------------------
package rca_pkg;

    localparam int RCA_SEG_W = 32;

    typedef logic [RCA_SEG_W-1:0] seg_t;

    function automatic int nseg(input int width, input int seg_w);
        return width / seg_w;
    endfunction

endpackage

`define RCA_WIDTH_CHECK(W, S) \
    if ((S) <= 0 || (W) < (S) || ((W) % (S)) != 0) begin : g_width_check \
        $error("rca: WIDTH must be a positive multiple of SEG_W"); \
    end

// File: rtl/rca_seg.sv
// ----------------------------------------------------------------------------
// rca_seg
//   Combinational SEG_W-bit ripple-carry adder built from a chain of full
//   adders. Each bit's carry is a separate net inside its own generate
//   block, so the chain is a plain netlist and has no self-dependent vector.
//   Ports:
//     a_i, b_i  in   SEG_W  segment operands
//     cin_i     in   1      carry into bit 0 of the segment
//     s_o       out  SEG_W  segment sum
//     cout_o    out  1      carry out of the top bit of the segment
// ----------------------------------------------------------------------------
module rca_seg #(
    parameter int SEG_W = 32
) (
    input  logic [SEG_W-1:0] a_i,
    input  logic [SEG_W-1:0] b_i,
    input  logic             cin_i,
    output logic [SEG_W-1:0] s_o,
    output logic             cout_o
);

    genvar gi;
    for (gi = 0; gi < SEG_W; gi++) begin : g_fa
        logic ci;
        logic co;
        if (gi == 0) begin : g_lsb
            assign ci = cin_i;
        end else begin : g_chain
            assign ci = g_fa[gi-1].co;
        end
        assign s_o[gi] = a_i[gi] ^ b_i[gi] ^ ci;
        assign co      = (a_i[gi] & b_i[gi]) | (ci & (a_i[gi] ^ b_i[gi]));
    end

    assign cout_o = g_fa[SEG_W-1].co;

endmodule

// File: rtl/rca_seg_pipe_adder.sv
// ----------------------------------------------------------------------------
// rca_seg_pipe_adder
//   Pipelined segmented ripple-carry adder. The WIDTH-bit add is split into
//   NSEG = WIDTH/SEG_W segments. There is one register stage per segment.
//   Stage k adds segment k using the carry registered by stage k-1.
//   Operand segments above k ride a skew chain. Finished sum segments ride
//   along to the output. The last stage register is the output register.
//   Latency is NSEG cycles and throughput is one add per clock.
//
//   Optional feature macro: RCA_SUB_EN
//     When defined, the block gains a 'sub' input. With sub=1 it computes
//     a + ~b + 1 and ignores cin; cout=1 then means "no borrow".
//     When undefined, the block is add-only and has no 'sub' port.
//
//   Ports:
//     clk        in   1      rising-edge clock
//     rst_n      in   1      asynchronous active-low reset
//     in_valid   in   1      a/b/cin (and sub) valid this cycle
//     in_ready   out  1      block accepts input this cycle
//     a, b       in   WIDTH  operands
//     cin        in   1      carry into bit 0
//     sub        in   1      subtract select (RCA_SUB_EN only)
//     out_valid  out  1      s/cout valid
//     out_ready  in   1      downstream accepts s/cout
//     s          out  WIDTH  sum
//     cout       out  1      carry out of bit WIDTH-1
// ----------------------------------------------------------------------------
module rca_seg_pipe_adder
    import rca_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int SEG_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef RCA_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    localparam int NSEG = nseg(WIDTH, SEG_W);

    `RCA_WIDTH_CHECK(WIDTH, SEG_W)

    // A single enable moves the whole pipe. It stalls only when the output
    // register holds a result that downstream has not taken.
    logic en;
    assign en       = out_ready | ~out_valid;
    assign in_ready = en;

    // Subtraction is folded in at the input. B is inverted before it enters
    // the skew chain and the carry-in is forced to 1.
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
`ifdef RCA_SUB_EN
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub | cin;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    genvar gi;
    for (gi = 0; gi < NSEG; gi++) begin : g_stage
        localparam int SUM_W = (gi + 1) * SEG_W;   // sum bits finished after this stage
        localparam int OP_W  = WIDTH - SUM_W;      // operand bits still waiting

        logic             v_in;
        logic [SEG_W-1:0] seg_a;
        logic [SEG_W-1:0] seg_b;
        logic             seg_ci;
        logic [SEG_W-1:0] seg_s;
        logic             seg_co;

        logic             valid_q;
        logic             valid_d;
        logic             carry_q;
        logic             carry_d;
        logic [SUM_W-1:0] sum_q;
        logic [SUM_W-1:0] sum_d;

        if (gi == 0) begin : g_first
            assign v_in   = in_valid;
            assign seg_a  = a[SEG_W-1:0];
            assign seg_b  = b_eff[SEG_W-1:0];
            assign seg_ci = cin_eff;
            assign sum_d  = v_in ? seg_s : '0;
        end else begin : g_next
            assign v_in   = g_stage[gi-1].valid_q;
            assign seg_a  = g_stage[gi-1].g_ops.opa_q[SEG_W-1:0];
            assign seg_b  = g_stage[gi-1].g_ops.opb_q[SEG_W-1:0];
            assign seg_ci = g_stage[gi-1].carry_q;
            assign sum_d  = v_in ? {seg_s, g_stage[gi-1].sum_q} : '0;
        end

        rca_seg #(
            .SEG_W (SEG_W)
        ) u_seg (
            .a_i    (seg_a),
            .b_i    (seg_b),
            .cin_i  (seg_ci),
            .s_o    (seg_s),
            .cout_o (seg_co)
        );

        // Bubbles still advance, but they carry zeros so the output holds a
        // defined value even when out_valid is low.
        assign valid_d = v_in;
        assign carry_d = v_in & seg_co;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else if (en) begin
                valid_q <= valid_d;
                carry_q <= carry_d;
                sum_q   <= sum_d;
            end
        end

        // Skew chain for the operand segments this stage has not consumed.
        // The last stage has none.
        if (OP_W > 0) begin : g_ops
            logic [OP_W-1:0] opa_q;
            logic [OP_W-1:0] opb_q;
            logic [OP_W-1:0] opa_d;
            logic [OP_W-1:0] opb_d;

            if (gi == 0) begin : g_src_in
                assign opa_d = v_in ? a[WIDTH-1:SEG_W]     : '0;
                assign opb_d = v_in ? b_eff[WIDTH-1:SEG_W] : '0;
            end else begin : g_src_prev
                assign opa_d = v_in ? g_stage[gi-1].g_ops.opa_q[OP_W+SEG_W-1:SEG_W] : '0;
                assign opb_d = v_in ? g_stage[gi-1].g_ops.opb_q[OP_W+SEG_W-1:SEG_W] : '0;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    opa_q <= '0;
                    opb_q <= '0;
                end else if (en) begin
                    opa_q <= opa_d;
                    opb_q <= opb_d;
                end
            end
        end
    end

    assign out_valid = g_stage[NSEG-1].valid_q;
    assign s         = g_stage[NSEG-1].sum_q;
    assign cout      = g_stage[NSEG-1].carry_q;

endmodule

// File: tb/tb_rca_seg_pipe_adder.sv
// ----------------------------------------------------------------------------
// tb_rca_seg_pipe_adder
//   Self-checking bench for rca_seg_pipe_adder. Every accepted input is
//   turned into its expected {cout,s} by plain (WIDTH+1)-bit arithmetic and
//   queued. Every output transfer is queued as observed. Each test task
//   compares the two queues, and checks timing and stability, inline.
// ----------------------------------------------------------------------------
module tb_rca_seg_pipe_adder;

    parameter int WIDTH = 64;
    parameter int SEG_W = 32;
    localparam int NSEG = WIDTH / SEG_W;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub_v;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;

    always #5 clk = ~clk;

    rca_seg_pipe_adder #(
        .WIDTH (WIDTH),
        .SEG_W (SEG_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef RCA_SUB_EN
        .sub       (sub_v),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit in_acc = 1'b0;

    logic [WIDTH:0] exp_q[$];
    logic [WIDTH:0] obs_q[$];
    int             obs_cyc_q[$];

    // Reference: the whole-word result, with no segments involved.
    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y,
                                             input logic ci,
                                             input logic sb);
        logic [WIDTH:0] r;
        if (sb)
            r = {1'b0, x} + ((WIDTH+1)'(1) << WIDTH) - {1'b0, y};
        else
            r = {1'b0, x} + {1'b0, y} + (WIDTH+1)'(ci);
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] rand_word();
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < (WIDTH + 31) / 32; i++)
            r = (r << 32) | WIDTH'($urandom);
        case ($urandom_range(0, 7))
            0:       r = '1;
            1:       r = '0;
            default: ;
        endcase
        return r;
    endfunction

    function automatic logic rand_sub();
`ifdef RCA_SUB_EN
        return 1'($urandom);
`else
        return 1'b0;
`endif
    endfunction

    // Samples handshakes late in the cycle, then advances to 1 after the next edge.
    task automatic tick();
        #3;
        in_acc = in_valid && in_ready;
        if (in_acc)
            exp_q.push_back(model(a, b, cin, sub_v));
        if (out_valid && out_ready) begin
            obs_q.push_back({cout, s});
            obs_cyc_q.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_q();
        exp_q.delete();
        obs_q.delete();
        obs_cyc_q.delete();
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (obs_q.size() < exp_q.size() && n < 20 * NSEG + 20) begin
            tick();
            n++;
        end
        repeat (NSEG + 1) tick();
    endtask

    task automatic test_reset();
        bit seen;
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        a = rand_word(); b = rand_word(); cin = 1'b1; sub_v = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (s !== '0) begin errors++; $display("FAIL reset_s: got %h want 0", s); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b want 0", cout); end
        in_valid = 1'b0;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (2 * NSEG + 2) begin
            tick();
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("FAIL reset_idle_valid: out_valid rose with no input"); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        clear_q();
        $display("test_reset done");
    endtask

    task automatic test_carry();
        int lat;
        clear_q();
        out_ready = 1'b1; sub_v = 1'b0;
        a = '1; b = WIDTH'(1); cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 50) begin
            tick();
            lat++;
        end
        checks++; if (lat != NSEG) begin errors++; $display("FAIL carry_latency: got %0d want %0d", lat, NSEG); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL carry_valid: got %b want 1", out_valid); end
        checks++; if (s !== '0) begin errors++; $display("FAIL carry_s: got %h want 0", s); end
        checks++; if (cout !== 1'b1) begin errors++; $display("FAIL carry_cout: got %b want 1", cout); end
        drain();
        clear_q();
        $display("test_carry done: latency %0d", lat);
    endtask

    task automatic test_stream();
        logic [WIDTH-1:0] a3;
        logic [WIDTH:0]   e [3];
        clear_q();
        out_ready = 1'b1; sub_v = 1'b0; in_valid = 1'b1;
        a = WIDTH'(1); b = WIDTH'(2); cin = 1'b0;
        e[0] = (WIDTH+1)'(3);
        tick();
        a = '0; a[WIDTH-1] = 1'b1; b = a; cin = 1'b0;
        e[1] = (WIDTH+1)'(1) << WIDTH;
        tick();
        a3 = '0; a3[SEG_W-1:0] = '1;
        a = a3; b = WIDTH'(1); cin = 1'b1;
        e[2] = {1'b0, a3} + (WIDTH+1)'(2);
        tick();
        drain();
        checks++; if (obs_q.size() != 3) begin errors++; $display("FAIL stream_count: got %0d want 3", obs_q.size()); end
        for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== e[i]) begin
                errors++; $display("FAIL stream_value[%0d]: got %h want %h", i, obs_q[i], e[i]);
            end
        end
        for (int i = 1; i < 3 && i < obs_cyc_q.size(); i++) begin
            checks++;
            if (obs_cyc_q[i] != obs_cyc_q[i-1] + 1) begin
                errors++; $display("FAIL stream_consecutive[%0d]: cycle %0d after %0d", i, obs_cyc_q[i], obs_cyc_q[i-1]);
            end
        end
        clear_q();
        $display("test_stream done");
    endtask

    task automatic test_back_to_back();
        int bad;
        clear_q();
        in_valid = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!in_valid || in_acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                a = rand_word(); b = rand_word(); cin = 1'($urandom); sub_v = rand_sub();
            end
            out_ready = ($urandom_range(0, 4) > 1);
            tick();
        end
        drain();
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL random_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        bad = 0;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++; bad++;
                if (bad < 5) $display("FAIL random_value[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        $display("test_back_to_back done: %0d transactions", exp_q.size());
        clear_q();
    endtask

    task automatic test_backpressure();
        int n;
        logic [WIDTH-1:0] s_hold;
        logic             c_hold;
        clear_q();
        out_ready = 1'b0; sub_v = 1'b0; in_valid = 1'b1;
        a = rand_word(); b = rand_word(); cin = 1'($urandom);
        n = 0;
        while (in_ready !== 1'b0 && n < 50) begin
            tick();
            if (in_acc) begin a = rand_word(); b = rand_word(); cin = 1'($urandom); end
            n++;
        end
        checks++; if (exp_q.size() != NSEG) begin errors++; $display("FAIL bp_fill: accepted %0d want %0d", exp_q.size(), NSEG); end
        s_hold = s; c_hold = cout;
        repeat (3) begin
            tick();
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid: got %b want 1", out_valid); end
            checks++; if (s !== s_hold) begin errors++; $display("FAIL bp_s_stable: got %h want %h", s, s_hold); end
            checks++; if (cout !== c_hold) begin errors++; $display("FAIL bp_cout_stable: got %b want %b", cout, c_hold); end
        end
        out_ready = 1'b1;
        tick();
        drain();
        checks++; if (obs_q.size() != NSEG + 1) begin errors++; $display("FAIL bp_count: got %0d want %0d", obs_q.size(), NSEG + 1); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL bp_value[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        clear_q();
        $display("test_backpressure done");
    endtask

    task automatic test_reset_midflight();
        clear_q();
        out_ready = 1'b1; sub_v = 1'b0; in_valid = 1'b1;
        repeat (NSEG) begin
            a = rand_word(); b = rand_word(); cin = 1'($urandom);
            tick();
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_before: out_valid got %b want 1", out_valid); end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_async_valid: got %b want 0", out_valid); end
        checks++; if (s !== '0) begin errors++; $display("FAIL mid_async_s: got %h want 0", s); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_q();
        repeat (2 * NSEG + 2) tick();
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL mid_stale: %0d outputs after reset", obs_q.size()); end
        clear_q();
        $display("test_reset_midflight done");
    endtask

`ifdef RCA_SUB_EN
    task automatic test_sub();
        logic [WIDTH:0] e;
        clear_q();
        out_ready = 1'b1; in_valid = 1'b1;
        a = WIDTH'(5); b = WIDTH'(7); cin = 1'b0; sub_v = 1'b1;
        e = {1'b0, {WIDTH{1'b1}}} - (WIDTH+1)'(1);
        tick();
        in_valid = 1'b0; sub_v = 1'b0;
        drain();
        checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL sub_count: got %0d want 1", obs_q.size()); end
        if (obs_q.size() > 0) begin
            checks++;
            if (obs_q[0] !== e) begin errors++; $display("FAIL sub_value: got %h want %h", obs_q[0], e); end
        end
        clear_q();
        $display("test_sub done");
    endtask
`endif

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub_v = 1'b0;
        test_reset();
        test_carry();
        test_stream();
        test_backpressure();
        test_back_to_back();
        test_reset_midflight();
`ifdef RCA_SUB_EN
        test_sub();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
